// File: rtl/execute_stage_mc.sv
// rtl/execute_stage_mc.sv - MIPS execute stage with pipeline register, ALU and iterative multiplier
//
// Purpose:
//   Holds one instruction from decode in a stall/flush-aware pipeline register
//   and evaluates it in a combinational ALU. MULTU (and MULT when the optional
//   EXEC_MUL_SIGNED_EN macro is defined) run on a W-cycle shift-add engine that
//   writes HI/LO; decode is back-pressured while the engine is running.
//
// Optional feature macro: EXEC_MUL_SIGNED_EN (enables func 0x19 MULT, signed)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   in_valid   in   decode presents a valid instruction
//   in_ready   out  stage accepts this cycle (!busy && !stall_in)
//   stall_in   in   downstream stall, hold stage state
//   flush      in   kill held instruction, abort multiply
//   alu_func   in   6-bit operation select
//   ctrl_in    in   CW-bit control bundle
//   pc_seq_in  in   PC+4
//   a_in,b_in  in   operands
//   dest_in    in   write-back register index
//   read2_in   in   store data
//   out_valid  out  held result is valid
//   ctrl_out, pc_seq_out, dest_out, read2_out  out  registered pass-through fields
//   alu_out    out  result of the held instruction
//   busy       out  multiplier running

module execute_stage_mc #(
  parameter int W  = 32,
  parameter int CW = 14,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          stall_in,
  input  logic          flush,
  input  logic [5:0]    alu_func,
  input  logic [CW-1:0] ctrl_in,
  input  logic [W-1:0]  pc_seq_in,
  input  logic [W-1:0]  a_in,
  input  logic [W-1:0]  b_in,
  input  logic [RW-1:0] dest_in,
  input  logic [W-1:0]  read2_in,
  output logic          out_valid,
  output logic [CW-1:0] ctrl_out,
  output logic [W-1:0]  pc_seq_out,
  output logic [RW-1:0] dest_out,
  output logic [W-1:0]  read2_out,
  output logic [W-1:0]  alu_out,
  output logic          busy
);

  localparam int CNTW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(W - 1);

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULTU = 6'h18;
`ifdef EXEC_MUL_SIGNED_EN
  localparam logic [5:0] F_MULT  = 6'h19;
`endif
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic            busy_q;
  logic            valid_q;
  logic [5:0]      func_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [CW-1:0]   ctrl_q;
  logic [W-1:0]    pc_q;
  logic [RW-1:0]   dest_q;
  logic [W-1:0]    read2_q;
  logic [W-1:0]    hi_q;
  logic [W-1:0]    lo_q;
  logic [CNTW-1:0] cnt_q;
  logic [2*W-1:0]  acc_q;
  logic [W-1:0]    mcand_q;
`ifdef EXEC_MUL_SIGNED_EN
  logic            neg_q;
`endif

  // Multiply start decode and operand magnitudes presented to the engine
  logic           mul_start;
  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;
`ifdef EXEC_MUL_SIGNED_EN
  logic           signed_op;
  logic           neg_in;
`endif

  always_comb begin
    mag_a = a_in;
    mag_b = b_in;
`ifdef EXEC_MUL_SIGNED_EN
    signed_op = (alu_func == F_MULT);
    neg_in    = signed_op && (a_in[W-1] ^ b_in[W-1]);
    // Two's-complement magnitude; the most-negative value maps onto itself,
    // which is its correct unsigned magnitude.
    if (signed_op && a_in[W-1]) mag_a = ~a_in + W'(1);
    if (signed_op && b_in[W-1]) mag_b = ~b_in + W'(1);
    mul_start = in_valid && ((alu_func == F_MULTU) || signed_op);
`else
    mul_start = in_valid && (alu_func == F_MULTU);
`endif
  end

  // One shift-add step: add multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole accumulator right.
  // The carry out of the add becomes the new MSB.
  logic [W:0]     step_sum;
  logic [2*W-1:0] acc_step;
  logic [2*W-1:0] product;

  always_comb begin
    step_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? mcand_q : {W{1'b0}})};
    acc_step = {step_sum, acc_q[W-1:1]};
`ifdef EXEC_MUL_SIGNED_EN
    product  = neg_q ? (~acc_step + (2*W)'(1)) : acc_step;
`else
    product  = acc_step;
`endif
  end

  assign in_ready  = !busy_q && !stall_in;
  assign busy      = busy_q;
  assign out_valid = valid_q && !busy_q;
  assign ctrl_out   = ctrl_q;
  assign pc_seq_out = pc_q;
  assign dest_out   = dest_q;
  assign read2_out  = read2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      func_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      pc_q    <= '0;
      dest_q  <= '0;
      read2_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
`ifdef EXEC_MUL_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else if (flush) begin
      // Kill the held instruction and abandon any multiply; HI/LO untouched.
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      state   <= S_IDLE;
    end else if (in_ready) begin
      // Fields load on every accepted cycle; valid_q distinguishes bubbles.
      valid_q <= in_valid;
      func_q  <= alu_func;
      a_q     <= a_in;
      b_q     <= b_in;
      ctrl_q  <= ctrl_in;
      pc_q    <= pc_seq_in;
      dest_q  <= dest_in;
      read2_q <= read2_in;
      if (mul_start) begin
        state   <= S_MUL;
        busy_q  <= 1'b1;
        cnt_q   <= '0;
        acc_q   <= {{W{1'b0}}, mag_b};
        mcand_q <= mag_a;
`ifdef EXEC_MUL_SIGNED_EN
        neg_q   <= neg_in;
`endif
      end else begin
        state <= S_IDLE;
      end
    end else if (state == S_MUL) begin
      // Engine iterates regardless of downstream stall.
      acc_q <= acc_step;
      cnt_q <= cnt_q + CNTW'(1);
      if (cnt_q == LAST) begin
        hi_q   <= product[2*W-1:W];
        lo_q   <= product[W-1:0];
        busy_q <= 1'b0;
        state  <= S_DONE;
      end
    end
  end

  always_comb begin
    alu_out = '0;
    case (func_q)
      F_ADD:   alu_out = a_q + b_q;
      F_SUB:   alu_out = a_q - b_q;
      F_AND:   alu_out = a_q & b_q;
      F_OR:    alu_out = a_q | b_q;
      F_XOR:   alu_out = a_q ^ b_q;
      F_NOR:   alu_out = ~(a_q | b_q);
      F_SLT:   alu_out = {{(W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      F_SLTU:  alu_out = {{(W-1){1'b0}}, (a_q < b_q)};
      F_SLL:   alu_out = b_q << a_q[4:0];
      F_MFHI:  alu_out = hi_q;
      F_MFLO:  alu_out = lo_q;
      F_MULTU: alu_out = lo_q;
`ifdef EXEC_MUL_SIGNED_EN
      F_MULT:  alu_out = lo_q;
`endif
      default: alu_out = '0;
    endcase
  end

endmodule

// File: tb/tb_execute_stage_mc.sv
// tb/tb_execute_stage_mc.sv - self-checking bench for execute_stage_mc
module tb_execute_stage_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        stall_in;
  logic        flush;
  logic [5:0]  alu_func;
  logic [13:0] ctrl_in;
  logic [31:0] pc_seq_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [4:0]  dest_in;
  logic [31:0] read2_in;
  logic        out_valid;
  logic [13:0] ctrl_out;
  logic [31:0] pc_seq_out;
  logic [4:0]  dest_out;
  logic [31:0] read2_out;
  logic [31:0] alu_out;
  logic        busy;

  execute_stage_mc #(.W(32), .CW(14), .RW(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .stall_in(stall_in), .flush(flush), .alu_func(alu_func),
    .ctrl_in(ctrl_in), .pc_seq_in(pc_seq_in), .a_in(a_in), .b_in(b_in),
    .dest_in(dest_in), .read2_in(read2_in), .out_valid(out_valid),
    .ctrl_out(ctrl_out), .pc_seq_out(pc_seq_out), .dest_out(dest_out),
    .read2_out(read2_out), .alu_out(alu_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference state
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  logic [13:0] exp_ctrl;
  logic [31:0] exp_pc;
  logic [4:0]  exp_dest;
  logic [31:0] exp_read2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_alu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (f)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
      6'h2B: return (a < b) ? 32'd1 : 32'd0;
      6'h00: return b << (a & 32'd31);
      6'h10: return hi_m;
      6'h12: return lo_m;
      default: return 32'd0;
    endcase
  endfunction

  // Present one instruction for one edge; fields are randomised and remembered.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input logic v);
    alu_func  = f;
    a_in      = a;
    b_in      = b;
    in_valid  = v;
    ctrl_in   = 14'($urandom);
    pc_seq_in = $urandom;
    dest_in   = 5'($urandom);
    read2_in  = $urandom;
    exp_ctrl  = ctrl_in;
    exp_pc    = pc_seq_in;
    exp_dest  = dest_in;
    exp_read2 = read2_in;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic check_hilo(input string tag);
    issue(6'h10, $urandom, $urandom, 1'b1);
    check({tag, "_mfhi"}, alu_out, hi_m);
    issue(6'h12, $urandom, $urandom, 1'b1);
    check({tag, "_mflo"}, alu_out, lo_m);
  endtask

  task automatic run_mul(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input logic hold);
    logic [63:0] p;
    longint sa;
    longint sb;
    int n;
    if (f == 6'h18) begin
      p = {32'b0, a} * {32'b0, b};
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      p  = sa * sb;
    end
    issue(f, a, b, 1'b1);
    check("mul_busy_start", busy, 1);
    check("mul_in_ready_low", in_ready, 0);
    check("mul_out_valid_low", out_valid, 0);
    stall_in = hold;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("mul_busy_cycles", n, 32);
    hi_m = p[63:32];
    lo_m = p[31:0];
    check("mul_out_valid", out_valid, 1);
    check("mul_alu_lo", alu_out, lo_m);
    check("mul_in_ready_after", in_ready, !hold);
    stall_in = 1'b0;
    check_hilo("mul");
  endtask

  logic [5:0]  ops [14] = '{6'h00, 6'h10, 6'h12, 6'h20, 6'h22, 6'h24, 6'h25,
                            6'h26, 6'h27, 6'h2A, 6'h2B, 6'h01, 6'h21, 6'h3F};
  logic [31:0] edge_vals [5] = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1};

  initial begin
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic        v;
    logic [31:0] hold_alu;
    logic [31:0] save_hi;
    logic [31:0] save_lo;

    reset = 1'b0; in_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
    alu_func = '0; ctrl_in = '0; pc_seq_in = '0; a_in = '0; b_in = '0;
    dest_in = '0; read2_in = '0;
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_out", alu_out, 0);
    check("rst_ctrl_out", ctrl_out, 0);
    check("rst_pc_out", pc_seq_out, 0);
    check("rst_dest_out", dest_out, 0);
    check("rst_read2_out", read2_out, 0);
    reset = 1'b1;
    check("rst_in_ready", in_ready, 1);
    step();
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_alu_out", alu_out, 0);

    // Directed ALU cases
    issue(6'h20, 32'h7FFF_FFFF, 32'h1, 1'b1);
    check("add_out_valid", out_valid, 1);
    check("add_ovf", alu_out, 32'h8000_0000);
    issue(6'h2A, 32'hFFFF_FFFF, 32'h1, 1'b1);
    check("slt_neg", alu_out, 1);
    issue(6'h2B, 32'hFFFF_FFFF, 32'h1, 1'b1);
    check("sltu_big", alu_out, 0);
    step();
    check("bubble_out_valid", out_valid, 0);

    // Randomised ALU traffic
    for (int i = 0; i < 40; i++) begin
      f = ops[$urandom_range(0, 13)];
      a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
      v = ($urandom_range(0, 3) != 0);
      issue(f, a, b, v);
      check("rnd_out_valid", out_valid, v);
      check("rnd_alu_out", alu_out, exp_alu(f, a, b));
      check("rnd_ctrl_out", ctrl_out, exp_ctrl);
      check("rnd_pc_out", pc_seq_out, exp_pc);
      check("rnd_dest_out", dest_out, exp_dest);
      check("rnd_read2_out", read2_out, exp_read2);
    end

    // Multiplies
    run_mul(6'h18, 32'hFFFF_FFFF, 32'h2, 1'b0);
    check("multu_hi_const", hi_m, 32'h1);
    for (int i = 0; i < 3; i++) begin
      run_mul(6'h18, $urandom, $urandom, (i == 1));
    end

    // Stall holding an AND result
    issue(6'h24, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1);
    hold_alu = 32'hF0F0_1234 & 32'h0FF0_FFFF;
    check("and_result", alu_out, hold_alu);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_func = 6'h20; a_in = $urandom; b_in = $urandom; in_valid = 1'b1;
      ctrl_in = 14'($urandom); pc_seq_in = $urandom;
      step();
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_alu_out", alu_out, hold_alu);
      check("stall_ctrl_out", ctrl_out, exp_ctrl);
      check("stall_pc_out", pc_seq_out, exp_pc);
    end
    stall_in = 1'b0;
    in_valid = 1'b0;
    step();
    check("unstall_bubble", out_valid, 0);

    // Flush a plain instruction while a new one is offered
    issue(6'h20, 32'h1, 32'h2, 1'b1);
    check("pre_flush_valid", out_valid, 1);
    in_valid = 1'b1; alu_func = 6'h22; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_kills_load", out_valid, 0);

    // Flush at cycle 10 of a MULTU
    save_hi = hi_m;
    save_lo = lo_m;
    issue(6'h18, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    check("fl_mul_busy", busy, 1);
    repeat (9) step();
    check("fl_mul_busy_c10", busy, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_busy_clear", busy, 0);
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    check("fl_hi_kept", hi_m, save_hi);
    check_hilo("flush");

    // Func 0x19
`ifdef EXEC_MUL_SIGNED_EN
    run_mul(6'h19, 32'hFFFF_FFFD, 32'h5, 1'b0);
    check("mult_signed", {hi_m, lo_m}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_mul(6'h19, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_mul(6'h19, $urandom, $urandom, 1'b0);
`else
    issue(6'h19, 32'hFFFF_FFFD, 32'h5, 1'b1);
    check("mult_off_busy", busy, 0);
    check("mult_off_in_ready", in_ready, 1);
    check("mult_off_alu", alu_out, 0);
    check("mult_off_valid", out_valid, 1);
    step();
    check("mult_off_busy2", busy, 0);
    check_hilo("mult_off");
`endif

    // Reset in the middle of a multiply
    issue(6'h18, $urandom | 32'h1, $urandom | 32'h1, 1'b1);
    repeat (5) step();
    check("mid_busy", busy, 1);
    alu_func = '0; a_in = '0; b_in = '0; ctrl_in = '0; pc_seq_in = '0;
    dest_in = '0; read2_in = '0;
    #2 reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_alu_out", alu_out, 0);
    check("arst_ctrl_out", ctrl_out, 0);
    check("arst_pc_out", pc_seq_out, 0);
    step();
    reset = 1'b1;
    check("arst_in_ready", in_ready, 1);
    hi_m = '0;
    lo_m = '0;
    step();
    check("arst_busy_after", busy, 0);
    check_hilo("arst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
